host_bus_arbiter: RTL and testbench
===================================

Name: host_bus_arbiter

Overview:
- Shares one host register bus (wr_n / 16-bit address / 16-bit bidirectional data) among NREQ internal requesters, e.g. a config loader, a debug port and a CPU bridge.
- Arbitrates round-robin, then sequences each granted transaction onto the bus as a single-cycle write or a fixed-latency read.
- Returns read data and a completion pulse to the owning requester.
- Sits between the requesters and the register-bearing DUT's host port.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 16, address width
- DW, 16, data width
- READ_LAT, 1, cycles from address presented to data sampled (1..7)

Ports:
- clk  input  1  sole clock, all logic on posedge
- rst  input  1  asynchronous active-high reset
- req  input  NREQ  per-requester request; level, held until gnt
- req_wr  input  NREQ  1 = write, 0 = read
- req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  input  NREQ*DW  packed write data
- gnt  output  NREQ  one-hot, one-cycle pulse; transaction accepted and fields latched
- done  output  NREQ  one-hot, one-cycle completion pulse to the owner
- rdata  output  DW  read data, valid in the done cycle of a read
- busy  output  1  high from the cycle after gnt through the done cycle
- wr_n  output  1  host write strobe, active low
- address  output  AW  host address
- data  inout  DW  host data; driven only during the write cycle, else high-Z

Behaviour:
- Reset (async, immediate):
  - state=IDLE, wr_n=1, address=0, data high-Z, gnt=0, done=0, rdata=0, busy=0, rr pointer=NREQ-1 (requester 0 wins first).
- States: IDLE, WR, RD, CAP.
- IDLE:
  - If any req, gnt[winner]=1 this cycle (combinational from state + req).
  - Winner's wr/addr/wdata latched on that edge; rr pointer := winner; next = WR or RD.
  - If no req, stay IDLE.
- WR (1 cycle):
  - wr_n=0; address and data driven from latched fields (all registered); done[owner]=1.
  - next = IDLE.
- RD (READ_LAT cycles):
  - wr_n=1, address driven, data high-Z, 3-bit counter runs.
  - At the edge ending the READ_LAT-th RD cycle, data is sampled into rdata; next = CAP.
- CAP (1 cycle): done[owner]=1, rdata valid, address held; next = IDLE.
- Minimum one IDLE cycle between transactions; this provides the bus turnaround after a write.
  - Write throughput: 1 per 2 cycles.
  - Read latency, gnt to done: READ_LAT+1 cycles.
- Round-robin: search starts at pointer+1 modulo NREQ. The last winner has lowest priority next arbitration.
- Outside WR, wr_n is always 1. address holds its last value in IDLE. rdata holds until the next read capture.
- Owner dropping req after gnt: ignored; the transaction completes and done is still issued.
- Requester keeping req high after done: treated as a new transaction, arbitrated normally.
- Non-owners' reqs during a transaction: no effect until IDLE.
- Reset mid-transaction: aborted, no done issued, bus returns to the reset values immediately.
- done and gnt are never asserted in the same cycle.

Optional Feature:
- Macro: HOST_BUS_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. Whenever req[0] is high in IDLE it wins, and the rr pointer is not updated. Requesters 1..NREQ-1 round-robin among themselves.
- Undefined: pure round-robin over all NREQ.

Decomposition:
- Package host_bus_arb_pkg:
  - state enum (IDLE, WR, RD, CAP)
  - READ_LAT_MAX=7 constant
  - function to unpack requester field i from a packed vector
- One sub-module, host_rr_pick: combinational round-robin picker. Inputs: req vector, pointer, prio0 enable. Outputs: one-hot grant and winner index.

Test Plan:
- Single write: req[1]=1, wr=1, addr=0x0010, wdata=0xA5A5 -> gnt[1] in cycle 0; cycle 1 wr_n=0, address=0x0010, data=0xA5A5, done[1]=1; cycle 2 data=Z.
- Single read, READ_LAT=2: req[2] read addr=0x0024, DUT drives 0x1234 -> done[2] at gnt+3 cycles, rdata=0x1234, data never driven by the arbiter.
- Fairness: all four reqs held high with writes -> gnt order 0,1,2,3,0,1, one grant every 2 cycles. With HOST_BUS_ARB_PRIO0_EN defined -> gnt[0] every grant.
- Drop after grant: req[3] read, deasserted the cycle after gnt[3] -> transaction completes, done[3] issued, no second gnt[3].
- Reset mid-read: rst asserted during RD -> wr_n=1, address=0, busy=0 immediately; no done. After release, pending req[0] granted first.
- Back-to-back write then read from the same requester -> one IDLE cycle with data=Z between WR and RD; no bus contention.

Source files
------------

// File: rtl/host_bus_arb_pkg.sv
// Shared state type, limits and field-unpacking helper for host_bus_arbiter.
package host_bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} arbState_e;

  localparam int READ_LAT_MAX = 7;
  localparam int FIELD_MAX    = 64;
  localparam int VEC_MAX      = 512;

  typedef logic [VEC_MAX-1:0]   packedVec_t;
  typedef logic [FIELD_MAX-1:0] field_t;

  // Callers zero-extend their packed vector to VEC_MAX and truncate the result to their field width.
  function automatic field_t unpackField(input packedVec_t vec, input int idx, input int width);
    packedVec_t shifted;
    packedVec_t mask;
    shifted = vec >> (idx * width);
    mask    = (packedVec_t'(1) << width) - packedVec_t'(1);
    return field_t'(shifted & mask);
  endfunction

endpackage

// File: rtl/host_bus_arbiter_if.sv
// Requester-side handshake bundle: requesters drive the master modport, the arbiter the slave modport.
interface host_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  import host_bus_arb_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;

  modport master (
    output req, req_wr, req_addr, req_wdata,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    output gnt, done, rdata, busy
  );

endinterface

// File: rtl/host_rr_pick.sv
// Combinational round-robin picker: search starts one past the pointer; optional fixed priority for requester 0.
module host_rr_pick
  import host_bus_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            prio0En_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   winIdx_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] sel;
    gnt_o    = '0;
    winIdx_o = '0;
    found    = 1'b0;
    sel      = '0;
    if (prio0En_i && req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    for (int k = 1; k <= NREQ; k++) begin
      sel = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        winIdx_o   = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_bus_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one host register bus (single-cycle writes, fixed-latency reads).
// Define HOST_BUS_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module host_bus_arbiter
  import host_bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  host_bus_arbiter_if.slave bus,
  output logic              wr_n_o,
  output logic [AW-1:0]     address_o,
  inout  wire  [DW-1:0]     data_io
);

  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAT_EFF = (READ_LAT < 1) ? 1 :
                           ((READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT);
  localparam logic [2:0] LAT_LAST = 3'(LAT_EFF);

`ifdef HOST_BUS_ARB_PRIO0_EN
  localparam logic PRIO0_EN = 1'b1;
`else
  localparam logic PRIO0_EN = 1'b0;
`endif

  arbState_e       state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [NREQ-1:0] owner_q;
  logic [AW-1:0]   address_q;
  logic [DW-1:0]   wdata_q;
  logic            dataOe_q;
  logic            wrN_q;
  logic            busy_q;
  logic [NREQ-1:0] done_q;
  logic [DW-1:0]   rdata_q;
  logic [2:0]      cnt_q;

  logic [NREQ-1:0] pickGnt;
  logic [IW-1:0]   winIdx;
  logic [AW-1:0]   winAddr;
  logic [DW-1:0]   winWdata;
  logic            winWr;
  logic            anyReq;

  host_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) uPick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .prio0En_i (PRIO0_EN),
    .gnt_o     (pickGnt),
    .winIdx_o  (winIdx)
  );

  assign anyReq   = |bus.req;
  assign winWr    = bus.req_wr[winIdx];
  assign winAddr  = AW'(unpackField(packedVec_t'(bus.req_addr), int'(winIdx), AW));
  assign winWdata = DW'(unpackField(packedVec_t'(bus.req_wdata), int'(winIdx), DW));

  // A fixed-priority win by requester 0 must not disturb the rotation of the others.
  assign ptr_d = (PRIO0_EN && winIdx == '0) ? ptr_q : winIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      owner_q   <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      dataOe_q  <= 1'b0;
      wrN_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (anyReq) begin
            owner_q   <= pickGnt;
            ptr_q     <= ptr_d;
            address_q <= winAddr;
            wdata_q   <= winWdata;
            busy_q    <= 1'b1;
            if (winWr) begin
              state_q  <= WR;
              wrN_q    <= 1'b0;
              dataOe_q <= 1'b1;
              done_q   <= pickGnt;
            end else begin
              state_q <= RD;
              cnt_q   <= 3'd1;
            end
          end
        end
        WR: begin
          state_q  <= IDLE;
          wrN_q    <= 1'b1;
          dataOe_q <= 1'b0;
          done_q   <= '0;
          busy_q   <= 1'b0;
        end
        RD: begin
          if (cnt_q == LAT_LAST) begin
            rdata_q <= data_io;
            done_q  <= owner_q;
            state_q <= CAP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        CAP: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = (state_q == IDLE && !rst) ? pickGnt : '0;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign wr_n_o    = wrN_q;
  assign address_o = address_q;
  assign data_io   = dataOe_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Directed and randomised bench for host_bus_arbiter, checked against a transaction-level model with a 16-word host register file.
module tb_host_bus_arbiter;
  import host_bus_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int RL   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wrN;
  logic [AW-1:0] addrOut;
  wire  [DW-1:0] hostData;

  logic [DW-1:0] hostMem  [16];
  logic [DW-1:0] modelMem [16];

  bit            reqV   [NREQ];
  bit            wrV    [NREQ];
  logic [AW-1:0] addrV  [NREQ];
  logic [DW-1:0] wdataV [NREQ];

  int testsRun    = 0;
  int testsFailed = 0;

  int            cyc = 0;
  bit            active;
  int            gntCyc, owner, txnLen, ptr;
  bit            curWr;
  logic [AW-1:0] curAddr, lastAddr;
  logic [DW-1:0] curWdata, rdataExp;
  bit            randomMode = 0;
  bit            keepMode   = 0;
  int            grantLog [$];
  int            fairExp  [6];

  host_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  host_bus_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wr_n_o    (wrN),
    .address_o (addrOut),
    .data_io   (hostData)
  );

  // The host register file answers whenever the strobe is idle, as a real register block would.
  assign hostData = wrN ? hostMem[addrOut[3:0]] : {DW{1'bz}};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                = reqV[i];
      bus.req_wr[i]             = wrV[i];
      bus.req_addr[i*AW +: AW]  = addrV[i];
      bus.req_wdata[i*DW +: DW] = wdataV[i];
    end
  endtask

  function automatic int modelWinner(input int ptrIn);
`ifdef HOST_BUS_ARB_PRIO0_EN
    if (reqV[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++)
      if (reqV[(ptrIn + k) % NREQ]) return (ptrIn + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehotIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    active   = 0;
    ptr      = NREQ - 1;
    lastAddr = '0;
    rdataExp = '0;
  endtask

  task automatic randomFields(input int i);
    wrV[i]    = bit'($urandom_range(0, 1));
    addrV[i]  = AW'($urandom);
    wdataV[i] = DW'($urandom);
  endtask

  task automatic postGrant(input int w);
    if (randomMode) begin
      if ($urandom_range(0, 1) == 0) reqV[w] = 0;
      else randomFields(w);
    end else if (keepMode) begin
      wrV[w]    = 1;
      addrV[w]  = AW'($urandom);
      wdataV[w] = DW'($urandom);
    end else begin
      reqV[w] = 0;
    end
  endtask

  task automatic newRequests();
    if (randomMode)
      for (int i = 0; i < NREQ; i++)
        if (!reqV[i] && $urandom_range(0, 2) == 0) begin
          reqV[i] = 1;
          randomFields(i);
        end
  endtask

  task automatic stepCycle(input bit waitEdge);
    int              w, k;
    logic [NREQ-1:0] expGnt, expDone;
    logic            expBusy, expWrN;
    logic [AW-1:0]   expAddr;
    if (waitEdge) begin
      @(posedge clk);
      #1;
    end
    applyStimulus();
    #3;
    w = -1; k = 0; expGnt = '0; expDone = '0;
    if (!active) begin
      w = modelWinner(ptr);
      if (w >= 0) expGnt[w] = 1'b1;
      expBusy = 1'b0; expWrN = 1'b1; expAddr = lastAddr;
    end else begin
      k = cyc - gntCyc;
      expBusy = 1'b1; expWrN = !curWr; expAddr = curAddr;
      if (k == txnLen) begin
        expDone[owner] = 1'b1;
        if (!curWr) rdataExp = modelMem[curAddr[3:0]];
      end
    end
    checkOutput("gnt",     32'(bus.gnt),   32'(expGnt));
    checkOutput("done",    32'(bus.done),  32'(expDone));
    checkOutput("busy",    32'(bus.busy),  32'(expBusy));
    checkOutput("wr_n",    32'(wrN),       32'(expWrN));
    checkOutput("address", 32'(addrOut),   32'(expAddr));
    checkOutput("rdata",   32'(bus.rdata), 32'(rdataExp));
    if (active && curWr) checkOutput("wdata", 32'(hostData), 32'(curWdata));
    if (bus.gnt != '0) grantLog.push_back(onehotIdx(bus.gnt));
    if (!wrN) hostMem[addrOut[3:0]] = hostData;
    if (!active) begin
      if (w >= 0) begin
        active   = 1;
        gntCyc   = cyc;
        owner    = w;
        curWr    = wrV[w];
        curAddr  = addrV[w];
        curWdata = wdataV[w];
        txnLen   = curWr ? 1 : RL + 1;
        lastAddr = curAddr;
`ifdef HOST_BUS_ARB_PRIO0_EN
        if (w != 0) ptr = w;
`else
        ptr = w;
`endif
        postGrant(w);
      end
    end else begin
      if (curWr) modelMem[curAddr[3:0]] = curWdata;
      if (k == txnLen) active = 0;
    end
    newRequests();
    cyc++;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NREQ; i++) reqV[i] = 0;
  endtask

  initial begin
    int got;
    for (int i = 0; i < 16; i++) begin
      modelMem[i] = DW'($urandom);
      hostMem[i]  = modelMem[i];
    end
    modelMem[4] = 16'h1234;
    hostMem[4]  = 16'h1234;
    for (int i = 0; i < NREQ; i++) begin
      reqV[i] = 0; wrV[i] = 0; addrV[i] = '0; wdataV[i] = '0;
    end
    applyStimulus();
    modelReset();

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_n",    32'(wrN),       32'd1);
    checkOutput("rst_address", 32'(addrOut),   32'd0);
    checkOutput("rst_busy",    32'(bus.busy),  32'd0);
    checkOutput("rst_gnt",     32'(bus.gnt),   32'd0);
    checkOutput("rst_done",    32'(bus.done),  32'd0);
    checkOutput("rst_rdata",   32'(bus.rdata), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    stepCycle(0);

    // Fairness: every requester holds a write request continuously.
`ifdef HOST_BUS_ARB_PRIO0_EN
    fairExp = '{0, 0, 0, 0, 0, 0};
`else
    fairExp = '{0, 1, 2, 3, 0, 1};
`endif
    grantLog.delete();
    keepMode = 1;
    for (int i = 0; i < NREQ; i++) begin
      reqV[i] = 1; wrV[i] = 1; addrV[i] = AW'($urandom); wdataV[i] = DW'($urandom);
    end
    repeat (12) stepCycle(1);
    keepMode = 0;
    clearReqs();
    repeat (2) stepCycle(1);
    for (int i = 0; i < 6; i++) begin
      got = (i < grantLog.size()) ? grantLog[i] : -1;
      checkOutput($sformatf("fair_%0d", i), 32'(got), 32'(fairExp[i]));
    end

    // Single write.
    reqV[1] = 1; wrV[1] = 1; addrV[1] = 16'h0010; wdataV[1] = 16'hA5A5;
    repeat (3) stepCycle(1);
    checkOutput("wr_hostreg", 32'(hostMem[0]), 32'h0000A5A5);

    // Single read.
    reqV[2] = 1; wrV[2] = 0; addrV[2] = 16'h0024;
    repeat (RL + 3) stepCycle(1);
    checkOutput("rd_rdata", 32'(bus.rdata), 32'h00001234);

    // Owner drops its request right after the grant.
    reqV[3] = 1; wrV[3] = 0; addrV[3] = 16'h0035;
    repeat (RL + 4) stepCycle(1);

    // Same requester: write then read back the same register.
    reqV[1] = 1; wrV[1] = 1; addrV[1] = 16'h0031; wdataV[1] = 16'h5AA5;
    stepCycle(1);
    reqV[1] = 1; wrV[1] = 0; addrV[1] = 16'h0031;
    repeat (RL + 4) stepCycle(1);
    checkOutput("b2b_rdata", 32'(bus.rdata), 32'h00005AA5);

    // Reset in the middle of a read, with other requesters waiting.
    reqV[1] = 1; wrV[1] = 0; addrV[1] = 16'h0042;
    stepCycle(1);
    reqV[0] = 1; wrV[0] = 1; addrV[0] = 16'h0007; wdataV[0] = 16'hC3C3;
    reqV[2] = 1; wrV[2] = 1; addrV[2] = 16'h0008; wdataV[2] = 16'h3C3C;
    stepCycle(1);
    @(posedge clk);
    #1 applyStimulus();
    #1 rst = 1'b1;
    #1;
    checkOutput("mr_wr_n",    32'(wrN),      32'd1);
    checkOutput("mr_address", 32'(addrOut),  32'd0);
    checkOutput("mr_busy",    32'(bus.busy), 32'd0);
    checkOutput("mr_done",    32'(bus.done), 32'd0);
    checkOutput("mr_gnt",     32'(bus.gnt),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    stepCycle(0);
    checkOutput("mr_first", 32'(bus.gnt), 32'd1);
    repeat (6) stepCycle(1);

    // Randomised traffic.
    randomMode = 1;
    repeat (400) stepCycle(1);
    randomMode = 0;
    clearReqs();
    repeat (RL + 4) stepCycle(1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
